// File: rtl/clkdiv_rate_sched.sv
// Fractional clock-enable generator with a programmable INC/MOD rate table and glitch-free rate switching.
// Optional hold handshake (hold_req/hold_ack) is built when CLKDIV_HOLD_EN is defined.
module clkdiv_rate_sched #(
    parameter int ACC_W     = 28,
    parameter int NUM_SLOTS = 4,
    parameter int DEF_INC   = 3579545,
    parameter int DEF_MOD   = 62500000,
    localparam int SW       = $clog2(NUM_SLOTS)
) (
    input  logic             clk_src,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_slot,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic [ACC_W-1:0] cfg_mod,
    output logic             cfg_err,
    input  logic             sel_valid,
    input  logic [SW-1:0]    sel_slot,
    output logic             sel_ready,
    output logic [SW-1:0]    active_slot,
`ifdef CLKDIV_HOLD_EN
    input  logic             hold_req,
    output logic             hold_ack,
`endif
    output logic             clk_en,
    output logic             clk_out
);

    typedef enum logic [1:0] {ST_RUN, ST_PEND, ST_SWITCH, ST_HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] tbl_inc_q [NUM_SLOTS];
    logic [ACC_W-1:0] tbl_mod_q [NUM_SLOTS];
    logic [ACC_W-1:0] tbl_inc_d [NUM_SLOTS];
    logic [ACC_W-1:0] tbl_mod_d [NUM_SLOTS];
    logic [ACC_W-1:0] run_inc_q, run_inc_d, run_mod_q, run_mod_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_nxt;
    logic [SW-1:0]    pend_slot_q, pend_slot_d, active_slot_q, active_slot_d;
    logic             clk_en_q, clk_en_d, clk_out_q, clk_out_d, cfg_err_q, cfg_err_d;
    logic             cfg_ok, wrap;
    logic [ACC_W:0]   sum;

    always_comb begin
        cfg_ok    = (cfg_mod != '0) && (cfg_inc < cfg_mod);
        cfg_err_d = cfg_we && !cfg_ok;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            tbl_inc_d[i] = tbl_inc_q[i];
            tbl_mod_d[i] = tbl_mod_q[i];
        end
        if (cfg_we && cfg_ok) begin
            tbl_inc_d[cfg_slot] = cfg_inc;
            tbl_mod_d[cfg_slot] = cfg_mod;
        end

        // Valid config keeps acc < mod, so a single conditional subtract suffices.
        sum     = {1'b0, acc_q} + {1'b0, run_inc_q};
        wrap    = sum >= {1'b0, run_mod_q};
        acc_nxt = wrap ? ACC_W'(sum - {1'b0, run_mod_q}) : sum[ACC_W-1:0];

        state_d       = state_q;
        acc_d         = acc_q;
        clk_en_d      = 1'b0;
        run_inc_d     = run_inc_q;
        run_mod_d     = run_mod_q;
        pend_slot_d   = pend_slot_q;
        active_slot_d = active_slot_q;

        case (state_q)
            ST_RUN: begin
                acc_d    = acc_nxt;
                clk_en_d = wrap;
                if (sel_valid) begin
                    pend_slot_d = sel_slot;
                    state_d     = ST_PEND;
                end
`ifdef CLKDIV_HOLD_EN
                else if (hold_req && clk_en_q) begin
                    // Freeze on the pulse boundary so the phase resumes untouched.
                    state_d  = ST_HOLD;
                    acc_d    = acc_q;
                    clk_en_d = 1'b0;
                end
`endif
            end
            ST_PEND: begin
                if (clk_en_q || run_inc_q == '0) begin
                    state_d = ST_SWITCH;
                end else begin
                    acc_d    = acc_nxt;
                    clk_en_d = wrap;
                end
            end
            ST_SWITCH: begin
                // Reads the post-write table, so a same-cycle write to pend_slot wins.
                run_inc_d     = tbl_inc_d[pend_slot_q];
                run_mod_d     = tbl_mod_d[pend_slot_q];
                acc_d         = '0;
                active_slot_d = pend_slot_q;
                state_d       = ST_RUN;
            end
`ifdef CLKDIV_HOLD_EN
            ST_HOLD: begin
                if (!hold_req) state_d = ST_RUN;
            end
`else
            default: state_d = ST_RUN;
`endif
        endcase

        clk_out_d = clk_out_q ^ clk_en_d;
    end

    always_ff @(posedge clk_src or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            run_inc_q     <= ACC_W'(DEF_INC);
            run_mod_q     <= ACC_W'(DEF_MOD);
            acc_q         <= '0;
            pend_slot_q   <= '0;
            active_slot_q <= '0;
            clk_en_q      <= 1'b0;
            clk_out_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tbl_inc_q[i] <= ACC_W'(DEF_INC);
                tbl_mod_q[i] <= ACC_W'(DEF_MOD);
            end
        end else begin
            state_q       <= state_d;
            run_inc_q     <= run_inc_d;
            run_mod_q     <= run_mod_d;
            acc_q         <= acc_d;
            pend_slot_q   <= pend_slot_d;
            active_slot_q <= active_slot_d;
            clk_en_q      <= clk_en_d;
            clk_out_q     <= clk_out_d;
            cfg_err_q     <= cfg_err_d;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                tbl_inc_q[i] <= tbl_inc_d[i];
                tbl_mod_q[i] <= tbl_mod_d[i];
            end
        end
    end

    assign sel_ready   = (state_q == ST_RUN);
    assign active_slot = active_slot_q;
    assign clk_en      = clk_en_q;
    assign clk_out     = clk_out_q;
    assign cfg_err     = cfg_err_q;
`ifdef CLKDIV_HOLD_EN
    assign hold_ack    = (state_q == ST_HOLD);
`endif

endmodule
